// File: rtl/sdf_pkg.sv
// Shared definitions for the radix-2^2 SDF FFT pipeline: default stream
// widths, log2 helper and the bit-reversal used by the output reorder stage.
package sdf_pkg;

  localparam int SDF_N     = 64;
  localparam int SDF_WIDTH = 8;
  localparam int SDF_LOGN  = $clog2(SDF_N);

  // One stream sample as carried between stages (re in the upper half).
  typedef struct packed {
    logic [SDF_WIDTH-1:0] re;
    logic [SDF_WIDTH-1:0] im;
  } sdf_sample_t;

  function automatic int sdf_logn(input int n);
    return $clog2(n);
  endfunction

  // Reverses the low 'bits' bits of v; bits above are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) r = {r[30:0], v[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_pingpong_ram.sv
// Two-bank simple dual-port RAM for the reorder stage: bank bit selects the
// half, synchronous registered read.
module sdf_pingpong_ram
  import sdf_pkg::*;
#(
  parameter int N     = SDF_N,
  parameter int WIDTH = SDF_WIDTH,
  parameter int LOGN  = sdf_logn(N)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic                 wr_bank,
  input  logic [LOGN-1:0]      wr_addr,
  input  logic [2*WIDTH-1:0]   wr_data,
  input  logic                 rd_en,
  input  logic                 rd_bank,
  input  logic [LOGN-1:0]      rd_addr,
  output logic [2*WIDTH-1:0]   rd_data
);

  logic [2*WIDTH-1:0] mem [2*N];
  logic [2*WIDTH-1:0] rd_data_d;
  logic [2*WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[{rd_bank, rd_addr}];
  end

  // Storage and read register are deliberately unreset; the consumer qualifies
  // the data with its own valid pipeline.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sdf_bitrev_reorder.sv
// Output reorder stage: writes each bit-reversed frame into a ping-pong
// buffer and streams the completed bank back out in natural order.
module sdf_bitrev_reorder
  import sdf_pkg::*;
#(
  parameter int N     = SDF_N,
  parameter int WIDTH = SDF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);

  localparam int              LOGN = sdf_logn(N);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  logic [LOGN-1:0]  wr_cnt_d, wr_cnt_q;
  logic             wr_bank_d, wr_bank_q;
  logic [LOGN-1:0]  rd_cnt_d, rd_cnt_q;
  logic             rd_bank_d, rd_bank_q;
  logic             rd_active_d, rd_active_q;
  logic             rd_active_d1_d, rd_active_d1_q;
  logic             enable_out_d, enable_out_q;
  logic [WIDTH-1:0] out_re_d, out_re_q;
  logic [WIDTH-1:0] out_im_d, out_im_q;

  logic               launch;
  logic [LOGN-1:0]    wr_addr;
  logic [2*WIDTH-1:0] rd_data;

  always_comb begin
    launch  = enable_in && (wr_cnt_q == LAST);
    wr_addr = LOGN'(bitrev(32'(wr_cnt_q), LOGN));

    // Any gap in enable_in abandons the partial frame without toggling banks.
    wr_cnt_d  = enable_in ? wr_cnt_q + 1'b1 : '0;
    wr_bank_d = launch ? ~wr_bank_q : wr_bank_q;

    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_active_d = rd_active_q;
    if (launch) begin
      rd_bank_d   = wr_bank_q;
      rd_cnt_d    = '0;
      rd_active_d = 1'b1;
    end else if (rd_active_q) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST) rd_active_d = 1'b0;
    end

    rd_active_d1_d = rd_active_q;
    enable_out_d   = rd_active_d1_q;
    out_re_d       = rd_active_d1_q ? rd_data[2*WIDTH-1:WIDTH] : '0;
    out_im_d       = rd_active_d1_q ? rd_data[WIDTH-1:0]       : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q       <= '0;
      wr_bank_q      <= 1'b0;
      rd_cnt_q       <= '0;
      rd_bank_q      <= 1'b0;
      rd_active_q    <= 1'b0;
      rd_active_d1_q <= 1'b0;
      enable_out_q   <= 1'b0;
      out_re_q       <= '0;
      out_im_q       <= '0;
    end else begin
      wr_cnt_q       <= wr_cnt_d;
      wr_bank_q      <= wr_bank_d;
      rd_cnt_q       <= rd_cnt_d;
      rd_bank_q      <= rd_bank_d;
      rd_active_q    <= rd_active_d;
      rd_active_d1_q <= rd_active_d1_d;
      enable_out_q   <= enable_out_d;
      out_re_q       <= out_re_d;
      out_im_q       <= out_im_d;
    end
  end

  sdf_pingpong_ram #(
    .N     (N),
    .WIDTH (WIDTH),
    .LOGN  (LOGN)
  ) u_ram (
    .clk     (clk),
    .wr_en   (enable_in),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data ({in_re, in_im}),
    .rd_en   (rd_active_q),
    .rd_bank (rd_bank_q),
    .rd_addr (rd_cnt_q),
    .rd_data (rd_data)
  );

  assign enable_out = enable_out_q;
  assign out_re     = out_re_q;
  assign out_im     = out_im_q;

endmodule

// File: tb/tb_sdf_bitrev_reorder.sv
// Directed and randomised bench for the bit-reverse reorder stage, with an
// 8-point and a 64-point instance sharing one clock.
module tb_sdf_bitrev_reorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, en8, eo8;
  logic [7:0] re8, im8, or8, oi8;
  logic       rst64, en64, eo64;
  logic [7:0] re64, im64, or64, oi64;

  sdf_bitrev_reorder #(.N(8), .WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .enable_in(en8), .in_re(re8), .in_im(im8),
    .enable_out(eo8), .out_re(or8), .out_im(oi8)
  );

  sdf_bitrev_reorder #(.N(64), .WIDTH(8)) dut64 (
    .clk(clk), .rst(rst64), .enable_in(en64), .in_re(re64), .in_im(im64),
    .enable_out(eo64), .out_re(or64), .out_im(oi64)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] q8[$];
  logic [15:0] q64[$];
  logic [15:0] e8, e64;
  int run8 = 0, run64 = 0, last_run8 = 0, cnt64 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst8) begin
      chk("rst_en8", 32'(eo8), 0);
      run8 = 0;
    end else if (eo8) begin
      run8++;
      if (q8.size() == 0) chk("spurious8", 1, 0);
      else begin
        e8 = q8.pop_front();
        chk("re8", 32'(or8), 32'(e8[15:8]));
        chk("im8", 32'(oi8), 32'(e8[7:0]));
      end
    end else begin
      if (run8 != 0) begin
        chk("run8", 32'(run8 % 8), 0);
        last_run8 = run8;
        run8 = 0;
      end
      chk("idle8", {16'h0, or8, oi8}, 0);
    end
  end

  always @(negedge clk) begin
    if (rst64) begin
      chk("rst_en64", 32'(eo64), 0);
      run64 = 0;
    end else if (eo64) begin
      run64++;
      cnt64++;
      if (q64.size() == 0) chk("spurious64", 1, 0);
      else begin
        e64 = q64.pop_front();
        chk("re64", 32'(or64), 32'(e64[15:8]));
        chk("im64", 32'(oi64), 32'(e64[7:0]));
      end
    end else begin
      if (run64 != 0) begin
        chk("run64", 32'(run64 % 64), 0);
        run64 = 0;
      end
      chk("idle64", {16'h0, or64, oi64}, 0);
    end
  end

  task automatic idle(input int c);
    repeat (c) @(negedge clk) begin
      en8  = 1'b0;
      en64 = 1'b0;
    end
  endtask

  // Drives in_s[0..cnt-1] in arrival order; when cnt==n the natural-order
  // expectation want_s[0..n-1] is queued on the last sample.
  task automatic send(input int which, input int n, input int cnt,
                      input logic [15:0] in_s[64], input logic [15:0] want_s[64]);
    for (int k = 0; k < cnt; k++) begin
      @(negedge clk);
      if (which == 8) begin
        en8 = 1'b1; re8 = in_s[k][15:8]; im8 = in_s[k][7:0];
      end else begin
        en64 = 1'b1; re64 = in_s[k][15:8]; im64 = in_s[k][7:0];
      end
      if (k == n - 1) begin
        for (int i = 0; i < n; i++) begin
          if (which == 8) q8.push_back(want_s[i]);
          else            q64.push_back(want_s[i]);
        end
      end
    end
  endtask

  task automatic build_ramp(input int n, input int bits, input logic [7:0] base,
                            output logic [15:0] in_s[64], output logic [15:0] want_s[64]);
    logic [7:0] v;
    for (int i = 0; i < 64; i++) begin
      in_s[i] = '0;
      want_s[i] = '0;
    end
    for (int k = 0; k < n; k++) begin
      v = base + 8'(brev(k, bits));
      in_s[k] = {v, ~v};
      v = base + 8'(k);
      want_s[k] = {v, ~v};
    end
  endtask

  task automatic build_rand(output logic [15:0] in_s[64], output logic [15:0] want_s[64]);
    for (int i = 0; i < 64; i++) want_s[i] = 16'($urandom);
    for (int k = 0; k < 64; k++) in_s[k] = want_s[brev(k, 6)];
  endtask

  logic [15:0] a_in[64], a_want[64], b_in[64], b_want[64];
  logic [7:0]  t1_re[8]   = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};

  initial begin
    rst8 = 1'b1; rst64 = 1'b1;
    en8 = 1'b0; re8 = '0; im8 = '0;
    en64 = 1'b0; re64 = '0; im64 = '0;

    // reset held with random inputs toggling
    repeat (8) @(negedge clk) begin
      en8 = 1'($urandom); re8 = 8'($urandom); im8 = 8'($urandom);
      en64 = 1'($urandom); re64 = 8'($urandom); im64 = 8'($urandom);
    end
    @(negedge clk);
    en8 = 1'b0; en64 = 1'b0;
    rst8 = 1'b0; rst64 = 1'b0;
    idle(3);

    // single frame, hand-written bit-reversed input, natural output expected
    for (int i = 0; i < 64; i++) begin a_in[i] = '0; a_want[i] = '0; end
    for (int k = 0; k < 8; k++) begin
      a_in[k]   = {t1_re[k], ~t1_re[k]};
      a_want[k] = {8'(k), ~8'(k)};
    end
    send(8, 8, 8, a_in, a_want);
    @(negedge clk);
    en8 = 1'b0;
    @(posedge clk); #1;
    chk("lat_t1_en", 32'(eo8), 0);
    @(posedge clk); #1;
    chk("lat_t2_en", 32'(eo8), 1);
    chk("lat_t2_re", 32'(or8), 0);
    chk("lat_t2_im", 32'(oi8), 32'hff);
    idle(14);
    chk("single_run", 32'(last_run8), 8);

    // back-to-back frames, second frame offset by 8
    build_ramp(8, 3, 8'd0, a_in, a_want);
    build_ramp(8, 3, 8'd8, b_in, b_want);
    send(8, 8, 8, a_in, a_want);
    send(8, 8, 8, b_in, b_want);
    idle(14);
    chk("b2b_run", 32'(last_run8), 16);

    // aborted partial frame followed by a complete one
    build_ramp(8, 3, 8'h40, a_in, a_want);
    send(8, 8, 5, a_in, a_want);
    idle(3);
    build_ramp(8, 3, 8'h80, b_in, b_want);
    send(8, 8, 8, b_in, b_want);
    idle(14);
    chk("abort_run", 32'(last_run8), 8);
    chk("q8_empty", 32'(q8.size()), 0);

    // reset asserted while output sample 20 of a 64-point frame is showing
    build_rand(a_in, a_want);
    send(64, 64, 64, a_in, a_want);
    @(negedge clk);
    en64 = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("mid_en", 32'(eo64), 1);
    chk("mid_re20", 32'(or64), 32'(a_want[20][15:8]));
    rst64 = 1'b1;
    #1;
    chk("rst_async_en", 32'(eo64), 0);
    chk("rst_async_out", {16'h0, or64, oi64}, 0);
    q64.delete();
    repeat (3) @(negedge clk);
    rst64 = 1'b0;
    idle(90);

    // 50 random frames with random idle gaps
    cnt64 = 0;
    for (int f = 0; f < 50; f++) begin
      build_rand(a_in, a_want);
      send(64, 64, 64, a_in, a_want);
      idle($urandom_range(0, 10));
    end
    idle(150);
    chk("rand_count", 32'(cnt64), 50 * 64);
    chk("q64_empty", 32'(q64.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
